// File: rtl/rvvi_pkg.sv
// Shared types and record layout helpers for the RVVI retirement scheduler.
package rvvi_pkg;

  localparam int unsigned RVVI_ORDER_W  = 64;
  localparam int unsigned RVVI_FLAG_W   = 7;

  // Bit offsets inside the 7-bit flags field {trap,halt,intr,mode[1:0],ixl[1:0]}.
  localparam int unsigned RVVI_FLG_IXL  = 0;
  localparam int unsigned RVVI_FLG_MODE = 2;
  localparam int unsigned RVVI_FLG_INTR = 4;
  localparam int unsigned RVVI_FLG_HALT = 5;
  localparam int unsigned RVVI_FLG_TRAP = 6;

  typedef enum logic [0:0] {StIdle, StLock} sched_state_e;

  function automatic int unsigned rvvi_rec_w(input int unsigned ilen, input int unsigned xlen);
    return RVVI_ORDER_W + ilen + xlen + RVVI_FLAG_W;
  endfunction

endpackage

// File: rtl/rvvi_retire_fifo.sv
// Per-hart record FIFO: up to ISSUE compacted writes per cycle, one read per cycle.
module rvvi_retire_fifo #(
  parameter int unsigned ISSUE = 1,
  parameter int unsigned DEPTH = 8,
  parameter int unsigned W     = 32,
  localparam int unsigned AW   = $clog2(DEPTH),
  localparam int unsigned PW   = AW + 1
) (
  input  logic                      clk,
  input  logic                      rst_n,
  input  logic [ISSUE-1:0]          wr_valid,
  input  logic [ISSUE-1:0][W-1:0]   wr_data,
  input  logic                      rd_en,
  output logic                      ready,
  output logic [W-1:0]              head,
  output logic [PW-1:0]             count
);

  logic [W-1:0]             mem [DEPTH];
  logic [PW-1:0]            wptr_q, wptr_d, rptr_q, rptr_d, npush;
  logic [ISSUE-1:0][PW-1:0] wr_pos;
  logic                     wr_en, empty, full;

  assign count = wptr_q - rptr_q;
  assign empty = (wptr_q == rptr_q);
  assign full  = (wptr_q[PW-1] != rptr_q[PW-1]) && (wptr_q[AW-1:0] == rptr_q[AW-1:0]);
  // Readiness only looks at the registered occupancy, never at this cycle's pop.
  assign ready = !full && (count <= PW'(DEPTH - ISSUE));
  assign wr_en = (|wr_valid) && ready;
  assign head  = mem[rptr_q[AW-1:0]];

  // Valid lanes land in consecutive slots in ascending lane order.
  always_comb begin
    npush  = '0;
    wr_pos = '0;
    for (int unsigned i = 0; i < ISSUE; i++) begin
      wr_pos[i] = wptr_q + npush;
      if (wr_valid[i]) npush = npush + 1'b1;
    end
  end

  assign wptr_d = wr_en ? (wptr_q + npush) : wptr_q;
  assign rptr_d = (rd_en && !empty) ? (rptr_q + 1'b1) : rptr_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wptr_q <= '0;
      rptr_q <= '0;
    end else begin
      wptr_q <= wptr_d;
      rptr_q <= rptr_d;
    end
  end

  always_ff @(posedge clk) begin
    for (int unsigned i = 0; i < ISSUE; i++) begin
      if (wr_en && wr_valid[i]) mem[wr_pos[i][AW-1:0]] <= wr_data[i];
    end
  end

endmodule

// File: rtl/rvvi_retire_scheduler.sv
// Merges per-hart retirement groups into one record stream with round-robin
// arbitration between harts and per-hart order-continuity checking.
module rvvi_retire_scheduler import rvvi_pkg::*; #(
  parameter int unsigned  NHART      = 1,
  parameter int unsigned  ISSUE      = 1,
  parameter int unsigned  ILEN       = 32,
  parameter int unsigned  XLEN       = 32,
  parameter int unsigned  DEPTH      = 8,
  parameter logic [63:0]  ORDER_INIT = 64'd1,
  localparam int unsigned HW         = $clog2(NHART) + 1,
  localparam int unsigned REC_W      = rvvi_rec_w(ILEN, XLEN)
) (
  input  logic                               clk,
  input  logic                               rst_n,
  input  logic [NHART-1:0][ISSUE-1:0]        in_valid,
  input  logic [NHART-1:0][ISSUE-1:0][63:0]  in_order,
  input  logic [NHART-1:0][ISSUE-1:0][ILEN-1:0] in_insn,
  input  logic [NHART-1:0][ISSUE-1:0][XLEN-1:0] in_pc,
  input  logic [NHART-1:0][ISSUE-1:0][6:0]   in_flags,
  output logic [NHART-1:0]                   in_ready,
  output logic                               out_valid,
  input  logic                               out_ready,
  output logic [HW-1:0]                      out_hart,
  output logic [REC_W-1:0]                   out_rec,
  output logic [NHART-1:0]                   err_order,
  output logic [NHART-1:0]                   err_ovf
);

  localparam int unsigned PW = $clog2(DEPTH) + 1;

  sched_state_e                  state_q, state_d;
  logic [HW-1:0]                 grant_q, grant_d, rr_q, rr_d, rr_next, arb_grant;
  logic                          arb_any, handshake;
  logic [NHART-1:0]              pop, avail;
  logic [NHART-1:0][REC_W-1:0]   head;
  logic [NHART-1:0][PW-1:0]      count;
  logic [NHART-1:0][63:0]        exp_q, exp_d;
  logic [NHART-1:0]              err_order_q, err_order_d, err_ovf_q, err_ovf_d;
  int unsigned                   idx;

  for (genvar h = 0; h < NHART; h++) begin : g_hart
    logic [ISSUE-1:0][REC_W-1:0] wr_data;
    for (genvar i = 0; i < ISSUE; i++) begin : g_lane
      assign wr_data[i] = {in_order[h][i], in_insn[h][i], in_pc[h][i], in_flags[h][i]};
    end
    rvvi_retire_fifo #(
      .ISSUE (ISSUE),
      .DEPTH (DEPTH),
      .W     (REC_W)
    ) u_fifo (
      .clk      (clk),
      .rst_n    (rst_n),
      .wr_valid (in_valid[h]),
      .wr_data  (wr_data),
      .rd_en    (pop[h]),
      .ready    (in_ready[h]),
      .head     (head[h]),
      .count    (count[h])
    );
  end

  assign handshake = (state_q == StLock) && out_ready;
  assign rr_next   = (grant_q == HW'(NHART - 1)) ? '0 : grant_q + 1'b1;
  assign rr_d      = handshake ? rr_next : rr_q;

  // Availability excludes the record being popped now so a hand-off can re-arbitrate at once.
  always_comb begin
    pop   = '0;
    avail = '0;
    for (int unsigned h = 0; h < NHART; h++) begin
      pop[h]   = handshake && (grant_q == HW'(h));
      avail[h] = count[h] > {{(PW-1){1'b0}}, pop[h]};
    end
  end

  always_comb begin
    arb_any   = 1'b0;
    arb_grant = '0;
    idx       = 0;
    for (int unsigned k = 0; k < NHART; k++) begin
      idx = (32'(rr_d) + k) % NHART;
      if (!arb_any && avail[idx]) begin
        arb_any   = 1'b1;
        arb_grant = HW'(idx);
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= StIdle;
      grant_q <= '0;
    end else begin
      state_q <= state_d;
      grant_q <= grant_d;
    end
  end

  always_comb begin
    state_d = state_q;
    grant_d = grant_q;
    unique case (state_q)
      StIdle: begin
        if (arb_any) begin
          state_d = StLock;
          grant_d = arb_grant;
        end
      end
      StLock: begin
        if (handshake) begin
          if (arb_any) grant_d = arb_grant;
          else         state_d = StIdle;
        end
      end
      default: state_d = StIdle;
    endcase
  end

  always_comb begin
    out_valid = (state_q == StLock);
    out_hart  = out_valid ? grant_q : '0;
    out_rec   = out_valid ? head[grant_q] : '0;
  end

  // A mismatch resyncs the expectation to the observed order, so both paths load order+1.
  always_comb begin
    exp_d       = exp_q;
    err_order_d = err_order_q;
    err_ovf_d   = err_ovf_q;
    for (int unsigned h = 0; h < NHART; h++) begin
      if (pop[h]) begin
        if (head[h][REC_W-1 -: 64] != exp_q[h]) err_order_d[h] = 1'b1;
        exp_d[h] = head[h][REC_W-1 -: 64] + 64'd1;
      end
      if ((|in_valid[h]) && !in_ready[h]) err_ovf_d[h] = 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rr_q        <= '0;
      exp_q       <= {NHART{ORDER_INIT}};
      err_order_q <= '0;
      err_ovf_q   <= '0;
    end else begin
      rr_q        <= rr_d;
      exp_q       <= exp_d;
      err_order_q <= err_order_d;
      err_ovf_q   <= err_ovf_d;
    end
  end

  assign err_order = err_order_q;
  assign err_ovf   = err_ovf_q;

endmodule
